me_candidate_fetch: RTL and testbench
=====================================

# me_candidate_fetch

Read-side fetch engine for the motion-estimation core. It reads the 16x16 current-block buffer and the 32x32 reference-window cache, both loaded by the 64-bit word write port. For one candidate displacement (dx, dy), it streams 16 rows of pixel pairs: the current row and the byte-aligned reference row at that displacement. Rows go through a valid/ready handshake to the downstream SAD datapath.

## Interface
- No parameters; all geometry constants come from the shared package.
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request one candidate; sampled only in IDLE.
- dx  in  5  horizontal displacement, legal 0..16.
- dy  in  5  vertical displacement, legal 0..16.
- busy  out  1  high from the cycle after an accepted start until done.
- err  out  1  one-cycle pulse when start is sampled in IDLE with dx>16 or dy>16.
- cur_rd_en  out  1  current-buffer read strobe.
- cur_rd_addr  out  5  current-buffer word address = row*2 + word.
- cur_rd_data  in  64  current-buffer data; valid the cycle after the strobe.
- ref_rd_en  out  1  reference-cache read strobe.
- ref_rd_addr  out  7  reference-cache word address = (dy+row)*4 + word.
- ref_rd_data  in  64  reference-cache data; valid the cycle after the strobe.
- row_valid  out  1  output row valid.
- row_ready  in  1  downstream accepts a row when valid && ready.
- row_idx  out  4  row number 0..15.
- row_last  out  1  high with row_idx==15.
- cur_row  out  128  current pixels 0..15; pixel k at bits [8k+7:8k].
- ref_row  out  128  reference pixels dx..dx+15 of window row dy+row_idx; same packing.
- done  out  1  one-cycle pulse after row 15 is accepted.

## Operation
- Pixel packing: pixel 0 of each 64-bit word sits in bits [7:0].
- States: IDLE, RD, CAP, OUT.
- IDLE:
  - start with legal dx/dy: latch dx/dy, set row=0, set k=0, go to RD.
  - start with an illegal value: pulse err and stay in IDLE.
- RD (k=0..2): issue one read per cycle, then go to CAP after k=2.
  - Reference read: word w0+k, where w0=dx>>3.
  - Current read: word k, only for k<2.
  - Exception: when dx==16 (w0=2) and k==2, ref_rd_en stays low and word 2 of the assembly is zero.
  - The third read is otherwise always issued, including when dx%8==0, so timing is fixed.
- CAP: capture the last returned word, form the rows, go to OUT.
  - Reference assembly: 192-bit {w2,w1,w0} shifted right by 8*(dx%8); keep the low 128 bits.
  - Current assembly: cur_row = {cword1, cword0}.
- OUT: row_valid high, row data held stable until the handshake.
  - On the handshake with row<15: row++, go to RD.
  - On the handshake with row==15: pulse done, go to IDLE.
- Address ranges: the highest reference address ever issued is 127 (dx=16, dy=16, row 15). The current buffer uses addresses 0..31.
- start while busy is ignored, with no err pulse.

## Timing
- Reset values: busy, err, row_valid, row_last, done, and both rd_en are 0. row_idx, both addresses, cur_row and ref_row are 0. FSM is in IDLE.
- Read latency: rd_en/addr asserted in cycle c means data is sampled at the end of cycle c+1.
- start sampled at edge t:
  - busy rises at t+1.
  - RD occupies t+1..t+3.
  - CAP at t+4.
  - First row_valid at t+5.
- Per row: 5 cycles minimum (3 RD + CAP + OUT); stall cycles with row_ready low add directly.
- With row_ready held high: row 15 is valid at t+80. done pulses and busy falls at t+81. A new start can be sampled at t+81.
- row_ready high outside OUT has no effect.
- rd_en is only ever high in RD.
- Reset mid-operation: immediate return to reset values. No done pulse, and no spurious row_valid after release.

## Structure
- Shared package me_pkg:
  - Constants: ME_PIX_W=8, ME_BLK=16, ME_WIN=32, ME_CUR_WORDS=2, ME_REF_WORDS=4, ME_MAX_DISP=16.
  - The fetch-state enum type.
- Sub-module me_row_aligner: purely combinational 192-to-128-bit byte shifter, taking {w2,w1,w0} and a 3-bit shift.

## Test plan
Memory preload: pixel(r,c) = (8r+c) mod 256 in the reference cache; pixel(r,c) = (r+c) in the current buffer.
- dx=0, dy=0, ready high:
  - Row 0: ref_row bytes 0..15 = 0x00..0x0F, cur_row bytes 0..15 = 0x00..0x0F.
  - done at t+81.
- dx=5, dy=3:
  - Row 0 ref addresses 12, 13, 14; ref_row byte0 = 0x1D, byte15 = 0x2C.
  - Row 15: byte0 = 0x95.
- dx=16, dy=16:
  - Row 15 ref addresses 126, 127, with no ref_rd_en on k=2.
  - ref_row byte0 = 0x08, byte15 = 0x17.
- Backpressure: row_ready low for 10 cycles while row 7 is valid.
  - Row 7 data and row_idx are stable, with no new reads.
  - done arrives at t+91.
- start with dx=17:
  - err is a one-cycle pulse; busy and all rd_en stay 0.
  - A following legal start is accepted normally.
- Reset asserted during row 4 OUT:
  - All outputs return to 0 asynchronously, with no done pulse.
  - A restart produces row 0 at 5 cycles after the new start.

Source files
------------

// File: rtl/me_pkg.sv
// me_pkg: geometry constants and fetch-state type shared by the motion-estimation fetch path.
package me_pkg;
    localparam int ME_PIX_W     = 8;
    localparam int ME_BLK       = 16;
    localparam int ME_WIN       = 32;
    localparam int ME_CUR_WORDS = 2;
    localparam int ME_REF_WORDS = 4;
    localparam int ME_MAX_DISP  = 16;
    localparam int ME_WORD_W    = 64;
    localparam int ME_ROW_W     = ME_PIX_W * ME_BLK;

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_CAP, ST_OUT} fetch_state_t;
endpackage

// File: rtl/me_row_aligner.sv
// me_row_aligner: selects 16 consecutive pixels from three packed reference words at a byte offset.
module me_row_aligner
    import me_pkg::*;
(
    input  logic [3*ME_WORD_W-1:0] i_words,
    input  logic [2:0]             i_shift,
    output logic [ME_ROW_W-1:0]    o_row
);
    assign o_row = ME_ROW_W'(i_words >> {i_shift, 3'b000});
endmodule

// File: rtl/me_candidate_fetch.sv
// me_candidate_fetch: streams 16 current/reference row pairs for one (dx, dy) candidate.
module me_candidate_fetch
    import me_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [4:0]           i_dx,
    input  logic [4:0]           i_dy,
    output logic                 o_busy,
    output logic                 o_err,
    output logic                 o_cur_rd_en,
    output logic [4:0]           o_cur_rd_addr,
    input  logic [ME_WORD_W-1:0] i_cur_rd_data,
    output logic                 o_ref_rd_en,
    output logic [6:0]           o_ref_rd_addr,
    input  logic [ME_WORD_W-1:0] i_ref_rd_data,
    output logic                 o_row_valid,
    input  logic                 i_row_ready,
    output logic [3:0]           o_row_idx,
    output logic                 o_row_last,
    output logic [ME_ROW_W-1:0]  o_cur_row,
    output logic [ME_ROW_W-1:0]  o_ref_row,
    output logic                 o_done
);
    fetch_state_t          r_state, w_next;
    logic [4:0]            r_dx, r_dy, w_ref_line;
    logic [3:0]            r_row;
    logic [1:0]            r_k;
    logic [ME_WORD_W-1:0]  r_rw0, r_rw1, w_rw2;
    logic [ME_ROW_W-1:0]   r_cur_row, r_ref_row, w_aligned;
    logic                  r_err, r_done, w_legal;

    assign w_legal    = i_dx <= 5'(ME_MAX_DISP) && i_dy <= 5'(ME_MAX_DISP);
    assign w_ref_line = r_dy + 5'(r_row);
    // dx==16 has no third reference word to read, so the top of the assembly is zero
    assign w_rw2      = r_dx[4] ? '0 : i_ref_rd_data;

    me_row_aligner u_align (
        .i_words (({w_rw2, r_rw1, r_rw0})),
        .i_shift (r_dx[2:0]),
        .o_row   (w_aligned)
    );

    always_comb begin
        w_next        = r_state;
        o_ref_rd_en   = 1'b0;
        o_cur_rd_en   = 1'b0;
        o_ref_rd_addr = '0;
        o_cur_rd_addr = '0;
        case (r_state)
            ST_IDLE: w_next = (i_start && w_legal) ? ST_RD : ST_IDLE;
            ST_RD: begin
                w_next        = (r_k == 2'd2) ? ST_CAP : ST_RD;
                o_ref_rd_en   = !(r_dx[4] && r_k == 2'd2);
                o_cur_rd_en   = r_k != 2'd2;
                o_ref_rd_addr = o_ref_rd_en ? {w_ref_line, 2'b00} + 7'(r_dx[4:3]) + 7'(r_k) : '0;
                o_cur_rd_addr = o_cur_rd_en ? {r_row, r_k[0]} : '0;
            end
            ST_CAP: w_next = ST_OUT;
            ST_OUT: w_next = !i_row_ready ? ST_OUT : (r_row == 4'd15) ? ST_IDLE : ST_RD;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_dx      <= '0;
            r_dy      <= '0;
            r_row     <= '0;
            r_k       <= '0;
            r_rw0     <= '0;
            r_rw1     <= '0;
            r_cur_row <= '0;
            r_ref_row <= '0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= r_state == ST_IDLE && i_start && !w_legal;
            r_done  <= r_state == ST_OUT && i_row_ready && r_row == 4'd15;
            case (r_state)
                ST_IDLE: if (i_start && w_legal) begin
                    r_dx  <= i_dx;
                    r_dy  <= i_dy;
                    r_row <= '0;
                    r_k   <= '0;
                end
                ST_RD: begin
                    r_k <= r_k + 2'd1;
                    // read data lags its strobe by one cycle
                    if (r_k == 2'd1) begin
                        r_rw0                     <= i_ref_rd_data;
                        r_cur_row[ME_WORD_W-1:0]  <= i_cur_rd_data;
                    end
                    if (r_k == 2'd2) begin
                        r_rw1                           <= i_ref_rd_data;
                        r_cur_row[ME_ROW_W-1:ME_WORD_W] <= i_cur_rd_data;
                    end
                end
                ST_CAP: r_ref_row <= w_aligned;
                ST_OUT: if (i_row_ready) begin
                    r_row <= r_row + 4'd1;
                    r_k   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_busy      = r_state != ST_IDLE;
    assign o_err       = r_err;
    assign o_done      = r_done;
    assign o_row_valid = r_state == ST_OUT;
    assign o_row_idx   = r_row;
    assign o_row_last  = r_state == ST_OUT && r_row == 4'd15;
    assign o_cur_row   = r_cur_row;
    assign o_ref_row   = r_ref_row;
endmodule

// File: tb/tb_me_candidate_fetch.sv
// tb_me_candidate_fetch: directed and randomized candidates checked against a pixel-level model.
module tb_me_candidate_fetch;
    logic         clk = 0, reset = 0, start = 0, row_ready = 0;
    logic [4:0]   dx = 0, dy = 0;
    logic         busy, err, cur_rd_en, ref_rd_en, row_valid, row_last, done;
    logic [4:0]   cur_rd_addr;
    logic [6:0]   ref_rd_addr;
    logic [63:0]  cur_rd_data = 0, ref_rd_data = 0;
    logic [3:0]   row_idx;
    logic [127:0] cur_row, ref_row;
    logic [7:0]   ref_pix [32][32];
    logic [7:0]   cur_pix [16][16];
    int           checks = 0, errors = 0, bad_rd = 0, done_at = 0;
    int           ref_q[$], cur_q[$];

    me_candidate_fetch dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_dx(dx), .i_dy(dy),
        .o_busy(busy), .o_err(err),
        .o_cur_rd_en(cur_rd_en), .o_cur_rd_addr(cur_rd_addr), .i_cur_rd_data(cur_rd_data),
        .o_ref_rd_en(ref_rd_en), .o_ref_rd_addr(ref_rd_addr), .i_ref_rd_data(ref_rd_data),
        .o_row_valid(row_valid), .i_row_ready(row_ready), .o_row_idx(row_idx),
        .o_row_last(row_last), .o_cur_row(cur_row), .o_ref_row(ref_row), .o_done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_word(input logic [6:0] a);
        logic [63:0] w;
        for (int j = 0; j < 8; j++) w[8*j +: 8] = ref_pix[int'(a) / 4][(int'(a) % 4) * 8 + j];
        return w;
    endfunction

    function automatic logic [63:0] cur_word(input logic [4:0] a);
        logic [63:0] w;
        for (int j = 0; j < 8; j++) w[8*j +: 8] = cur_pix[int'(a) / 2][(int'(a) % 2) * 8 + j];
        return w;
    endfunction

    function automatic logic [127:0] exp_ref(input int cdx, input int cdy, input int r);
        logic [127:0] v;
        for (int j = 0; j < 16; j++) v[8*j +: 8] = ref_pix[cdy + r][cdx + j];
        return v;
    endfunction

    function automatic logic [127:0] exp_cur(input int r);
        logic [127:0] v;
        for (int j = 0; j < 16; j++) v[8*j +: 8] = cur_pix[r][j];
        return v;
    endfunction

    // memories return data the cycle after a strobe; garbage otherwise
    always @(posedge clk) begin
        ref_rd_data <= ref_rd_en ? ref_word(ref_rd_addr) : {$urandom, $urandom};
        cur_rd_data <= cur_rd_en ? cur_word(cur_rd_addr) : {$urandom, $urandom};
        if (ref_rd_en) ref_q.push_back(int'(ref_rd_addr));
        if (cur_rd_en) cur_q.push_back(int'(cur_rd_addr));
        if ((ref_rd_en || cur_rd_en) && (row_valid || !busy)) bad_rd++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input bit rnd);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) ref_pix[r][c] = rnd ? 8'($urandom) : 8'(8 * r + c);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) cur_pix[r][c] = rnd ? 8'($urandom) : 8'(r + c);
    endtask

    // mode 0: ready high, 1: row 7 stalled 10 cycles, 2: random ready plus starts while busy
    task automatic run_cand(input int cdx, input int cdy, input int mode, output int dat);
        int n = 0, row = 0, stall = 0, errs = 0, mm = 0, ei = 0, ci = 0;
        bit fresh = 1;
        logic [127:0] hc = 0, hr = 0;
        logic [3:0] hi = 0;
        ref_q.delete();
        cur_q.delete();
        dat = -1;
        dx = 5'(cdx);
        dy = 5'(cdy);
        start = 1;
        @(posedge clk);
        #1 start = 0;
        while (dat < 0 && n < 800) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("busy_rise", 128'(busy), 128'(1));
            if (err) errs++;
            if (done) dat = n;
            else if (row_valid) begin
                start = 0;
                if (fresh) begin
                    chk("row_idx", 128'(row_idx), 128'(row));
                    chk("row_last", 128'(row_last), 128'(row == 15));
                    chk("cur_row", cur_row, exp_cur(row));
                    chk("ref_row", ref_row, exp_ref(cdx, cdy, row));
                    if (mode != 2) chk("row_time", 128'(n), 128'(5 + 5 * row + ((mode == 1 && row > 7) ? 10 : 0)));
                    hc = cur_row;
                    hr = ref_row;
                    hi = row_idx;
                    fresh = 0;
                end else begin
                    chk("hold_cur", cur_row, hc);
                    chk("hold_ref", ref_row, hr);
                    chk("hold_idx", 128'(row_idx), 128'(hi));
                end
                row_ready = mode == 0 ? 1'b1 : mode == 1 ? !(row == 7 && stall < 10) : ($urandom_range(3) != 0);
                if (!row_ready) stall++;
                if (row_ready) begin
                    row++;
                    fresh = 1;
                end
            end else begin
                row_ready = 1'($urandom % 2);
                if (mode == 2) begin
                    start = ($urandom % 3) == 0;
                    dx = 5'($urandom_range(20));
                    dy = 5'($urandom_range(20));
                end
            end
        end
        start = 0;
        chk("done_seen", 128'(dat >= 0), 128'(1));
        chk("rows_accepted", 128'(row), 128'(16));
        chk("busy_fall", 128'(busy), 128'(0));
        chk("no_err_while_busy", 128'(errs), 128'(0));
        chk("rd_outside_rd", 128'(bad_rd), 128'(0));
        for (int r = 0; r < 16; r++)
            for (int k = 0; k < 3; k++) begin
                if (!(cdx == 16 && k == 2)) begin
                    if (ei >= ref_q.size() || ref_q[ei] != (cdy + r) * 4 + cdx / 8 + k) mm++;
                    ei++;
                end
                if (k < 2) begin
                    if (ci >= cur_q.size() || cur_q[ci] != r * 2 + k) mm++;
                    ci++;
                end
            end
        chk("rd_addr_seq", 128'(mm), 128'(0));
        chk("ref_rd_count", 128'(ref_q.size()), 128'(ei));
        chk("cur_rd_count", 128'(cur_q.size()), 128'(ci));
        @(negedge clk);
        chk("done_one_cycle", 128'(done), 128'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {busy, err, cur_rd_en, ref_rd_en, row_valid, row_last, done, row_idx, cur_rd_addr, ref_rd_addr}, 128'(0));
        chk({tag, "_rows"}, cur_row | ref_row, 128'(0));
    endtask

    initial begin
        int n;
        preload(0);
        reset = 1;
        #2 chk_all_zero("reset_vals");
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk_all_zero("idle_vals");

        run_cand(0, 0, 0, done_at);
        chk("done_time_0_0", 128'(done_at), 128'(81));
        run_cand(5, 3, 0, done_at);
        chk("r15_b0_5_3", 128'(ref_row[7:0]), 128'(8'h95));
        run_cand(16, 16, 0, done_at);
        chk("r15_b0_16_16", 128'(ref_row[7:0]), 128'(8'h08));
        chk("r15_b15_16_16", 128'(ref_row[127:120]), 128'(8'h17));
        run_cand(9, 2, 1, done_at);
        chk("done_time_stall", 128'(done_at), 128'(91));

        dx = 17;
        dy = 0;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        @(negedge clk);
        chk("err_pulse_dx", {err, busy, ref_rd_en, cur_rd_en}, 128'(4'b1000));
        @(negedge clk);
        chk("err_clear", {err, busy, ref_rd_en, cur_rd_en}, 128'(0));
        dx = 0;
        dy = 17;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        @(negedge clk);
        chk("err_pulse_dy", {err, busy}, 128'(2'b10));
        @(negedge clk);
        run_cand(2, 9, 0, done_at);

        row_ready = 1;
        dx = 3;
        dy = 7;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        n = 0;
        while (!(row_valid && row_idx == 4) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_row4", 128'(row_valid && row_idx == 4), 128'(1));
        row_ready = 0;
        #2 reset = 1;
        #1 chk_all_zero("async_reset");
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold", {done, row_valid, busy}, 128'(0));
        end
        reset = 0;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_quiet", {done, row_valid, busy}, 128'(0));
        end
        run_cand(3, 7, 0, done_at);

        preload(1);
        run_cand(16, 16, 2, done_at);
        run_cand(0, 16, 2, done_at);
        run_cand(16, 0, 2, done_at);
        repeat (4) run_cand(int'($urandom_range(16)), int'($urandom_range(16)), 2, done_at);
        run_cand(int'($urandom_range(16)), int'($urandom_range(16)), 0, done_at);
        chk("done_time_rand", 128'(done_at), 128'(81));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
